// File: rtl/approx_ctrl_pkg.sv
// Shared types and helpers for the approximate-circuit sweep controller.
// Holds the FSM state encoding and the unsigned absolute-difference helper.
package approx_ctrl_pkg;

   typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

   localparam int unsigned DEF_N_IN = 4;
   localparam int unsigned NVEC     = 2**DEF_N_IN;

   // |a-b| on the low 'width' bits, formed as max-min so no sign handling is needed
   function automatic logic [31:0] abs_diff_u(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input int unsigned width);
      logic [31:0] mask;
      logic [31:0] am;
      logic [31:0] bm;
      mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
      am   = a & mask;
      bm   = b & mask;
      return (am > bm) ? (am - bm) : (bm - am);
   endfunction

endpackage

// File: rtl/approx_sweep_ctrl_accum.sv
// Error computation and statistics registers for one sweep:
// max error, error sum, violation count and first violating vector.
module approx_err_accum
   import approx_ctrl_pkg::*;
#(
   parameter int unsigned N_IN  = 4,
   parameter int unsigned N_OUT = 3,
   parameter int unsigned ET    = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  en,
   input  logic [N_IN-1:0]       vec,
   input  logic [N_OUT-1:0]      exact_in,
   input  logic [N_OUT-1:0]      approx_in,
   output logic [N_OUT-1:0]      max_err,
   output logic [N_OUT+N_IN-1:0] err_sum,
   output logic [N_IN:0]         viol_cnt,
   output logic [N_IN-1:0]       first_viol_vec,
   output logic                  first_viol_valid
);

   localparam logic [31:0] ET_W = 32'(ET);

   logic [N_OUT-1:0] err;
   logic             viol;

   always_comb begin
      err  = N_OUT'(abs_diff_u(32'(exact_in), 32'(approx_in), N_OUT));
      viol = 32'(err) > ET_W;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         max_err          <= '0;
         err_sum          <= '0;
         viol_cnt         <= '0;
         first_viol_vec   <= '0;
         first_viol_valid <= 1'b0;
      end else if (clr) begin
         max_err          <= '0;
         err_sum          <= '0;
         viol_cnt         <= '0;
         first_viol_vec   <= '0;
         first_viol_valid <= 1'b0;
      end else if (en) begin
         if (err > max_err) max_err <= err;
         err_sum <= err_sum + (N_OUT+N_IN)'(err);
         if (viol) begin
            viol_cnt <= viol_cnt + (N_IN+1)'(1);
            if (!first_viol_valid) begin
               first_viol_vec   <= vec;
               first_viol_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/approx_sweep_ctrl.sv
// Exhaustive-sweep controller: walks every input vector through an external
// exact/approximate circuit pair and accumulates error statistics.
module approx_sweep_ctrl
   import approx_ctrl_pkg::*;
#(
   parameter int unsigned N_IN   = 4,
   parameter int unsigned N_OUT  = 3,
   parameter int unsigned ET     = 3,
   parameter int unsigned SETTLE = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   output logic [N_IN-1:0]       vec_out,
   input  logic [N_OUT-1:0]      exact_in,
   input  logic [N_OUT-1:0]      approx_in,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [N_OUT-1:0]      max_err,
   output logic [N_OUT+N_IN-1:0] err_sum,
   output logic [N_IN:0]         viol_cnt,
   output logic [N_IN-1:0]       first_viol_vec,
   output logic                  first_viol_valid
);

   localparam logic [N_IN-1:0] LAST_VEC    = '1;
   localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);

   state_t          state, state_nxt;
   logic [3:0]      settle_cnt, settle_nxt;
   logic [N_IN-1:0] vec_nxt;
   logic            clr;
   logic            acc_en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         settle_cnt <= '0;
         vec_out    <= '0;
      end else begin
         state      <= state_nxt;
         settle_cnt <= settle_nxt;
         vec_out    <= vec_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      settle_nxt = settle_cnt;
      vec_nxt    = vec_out;
      clr        = 1'b0;
      acc_en     = 1'b0;
      case (state)
         IDLE, DONE: begin
            // abort beats start, so DONE results survive a simultaneous request
            if (start && !abort) begin
               state_nxt  = APPLY;
               vec_nxt    = '0;
               settle_nxt = '0;
               clr        = 1'b1;
            end
         end
         APPLY: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if (settle_cnt == SETTLE_LAST) begin
               state_nxt  = CHECK;
               settle_nxt = '0;
            end else begin
               settle_nxt = settle_cnt + 4'd1;
            end
         end
         CHECK: begin
            if (abort) begin
               state_nxt = IDLE;
            end else begin
               acc_en = 1'b1;
               if (vec_out == LAST_VEC) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt  = APPLY;
                  vec_nxt    = vec_out + N_IN'(1);
                  settle_nxt = '0;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state == APPLY) || (state == CHECK);
   assign done = (state == DONE);
   assign pass = done && (viol_cnt == '0);

   approx_err_accum #(
      .N_IN  (N_IN),
      .N_OUT (N_OUT),
      .ET    (ET)
   ) u_accum (
      .clk              (clk),
      .rst              (rst),
      .clr              (clr),
      .en               (acc_en),
      .vec              (vec_out),
      .exact_in         (exact_in),
      .approx_in        (approx_in),
      .max_err          (max_err),
      .err_sum          (err_sum),
      .viol_cnt         (viol_cnt),
      .first_viol_vec   (first_viol_vec),
      .first_viol_valid (first_viol_valid)
   );

endmodule
